// File: rtl/tdp_ram_param.sv
// ---------------------------------------------------------------------------
// tdp_ram_param
//   Parametrised common-clock true-dual-port RAM with byte-lane writes,
//   per-port read-during-write mode, optional output register and a
//   memory-clear sequencer that writes CLEAR_VALUE to every word.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_wen_x, i_ren_x           write / read enable, port x in {a, b}
//   i_be_x   [NUM_BYTES]       byte-lane write enables
//   i_addr_x [AW]              word address
//   i_wdata_x[DW]              write data
//   o_rdata_x[DW]              read data (registered, holds between reads)
//   o_rvalid_x                 one-cycle pulse, o_rdata_x valid
//   i_clear                    start memory clear (taken only when idle)
//   o_busy                     clear sequencer active
//   o_collision                one-cycle pulse, both ports wrote one address
// ---------------------------------------------------------------------------
module tdp_ram_param #(
  parameter  int unsigned DEPTH        = 1024,
  parameter  int unsigned BYTE_WIDTH   = 9,
  parameter  int unsigned NUM_BYTES    = 2,
  parameter  int unsigned WRITE_MODE_A = 0,
  parameter  int unsigned WRITE_MODE_B = 0,
  parameter  int unsigned OUT_REG      = 0,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned DW           = NUM_BYTES * BYTE_WIDTH,
  parameter  logic [DW-1:0] CLEAR_VALUE = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wen_a,
  input  logic                 i_ren_a,
  input  logic [NUM_BYTES-1:0] i_be_a,
  input  logic [AW-1:0]        i_addr_a,
  input  logic [DW-1:0]        i_wdata_a,
  output logic [DW-1:0]        o_rdata_a,
  output logic                 o_rvalid_a,
  input  logic                 i_wen_b,
  input  logic                 i_ren_b,
  input  logic [NUM_BYTES-1:0] i_be_b,
  input  logic [AW-1:0]        i_addr_b,
  input  logic [DW-1:0]        i_wdata_b,
  output logic [DW-1:0]        o_rdata_b,
  output logic                 o_rvalid_b,
  input  logic                 i_clear,
  output logic                 o_busy,
  output logic                 o_collision
);

  localparam int unsigned MODE_WRITE_FIRST = 0;
  localparam int unsigned MODE_NO_CHANGE   = 2;

  typedef enum logic {
    S_IDLE,
    S_CLEARING
  } state_t;

  // Storage array; deliberately not reset.
  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_addr;
  logic [AW-1:0] w_clr_addr_nxt;
  logic          w_busy_nxt;
  logic          w_clearing;

  logic          w_inr_a;
  logic          w_inr_b;
  logic          w_we_a;
  logic          w_we_b;
  logic          w_re_a;
  logic          w_re_b;
  logic [DW-1:0] w_old_a;
  logic [DW-1:0] w_old_b;
  logic [DW-1:0] w_merge_a;
  logic [DW-1:0] w_merge_b;
  logic          w_rd_vld_a;
  logic          w_rd_vld_b;
  logic [DW-1:0] w_rd_dat_a;
  logic [DW-1:0] w_rd_dat_b;

  logic          r_rd_vld_a;
  logic          r_rd_vld_b;
  logic [DW-1:0] r_rd_dat_a;
  logic [DW-1:0] r_rd_dat_b;
  logic          r_collision;

  // Port gating: clear owns the array; out-of-range addresses never write.
  assign w_clearing = (r_state == S_CLEARING);
  assign w_inr_a    = (32'(i_addr_a) < DEPTH);
  assign w_inr_b    = (32'(i_addr_b) < DEPTH);
  assign w_we_a     = i_wen_a & ~w_clearing & w_inr_a;
  assign w_we_b     = i_wen_b & ~w_clearing & w_inr_b;
  assign w_re_a     = i_ren_a & ~w_clearing;
  assign w_re_b     = i_ren_b & ~w_clearing;

  assign w_old_a = w_inr_a ? r_mem[i_addr_a] : '0;
  assign w_old_b = w_inr_b ? r_mem[i_addr_b] : '0;

  // Word as it will look after this port's own byte-lane write.
  always_comb begin
    w_merge_a = w_old_a;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (i_be_a[i]) begin
        w_merge_a[i*BYTE_WIDTH +: BYTE_WIDTH] = i_wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    w_merge_b = w_old_b;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (i_be_b[i]) begin
        w_merge_b[i*BYTE_WIDTH +: BYTE_WIDTH] = i_wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Port A read result, resolving same-port read-during-write.
  always_comb begin
    w_rd_vld_a = 1'b0;
    w_rd_dat_a = w_old_a;
    if (w_re_a) begin
      if (i_wen_a && (WRITE_MODE_A == MODE_NO_CHANGE)) begin
        w_rd_vld_a = 1'b0;
      end else begin
        w_rd_vld_a = 1'b1;
        if (!w_inr_a) begin
          w_rd_dat_a = '0;
        end else if (i_wen_a && (WRITE_MODE_A == MODE_WRITE_FIRST)) begin
          w_rd_dat_a = w_merge_a;
        end
      end
    end
  end

  // Port B read result, resolving same-port read-during-write.
  always_comb begin
    w_rd_vld_b = 1'b0;
    w_rd_dat_b = w_old_b;
    if (w_re_b) begin
      if (i_wen_b && (WRITE_MODE_B == MODE_NO_CHANGE)) begin
        w_rd_vld_b = 1'b0;
      end else begin
        w_rd_vld_b = 1'b1;
        if (!w_inr_b) begin
          w_rd_dat_b = '0;
        end else if (i_wen_b && (WRITE_MODE_B == MODE_WRITE_FIRST)) begin
          w_rd_dat_b = w_merge_b;
        end
      end
    end
  end

  // Array writes. Port A lanes are applied after port B so A wins per lane
  // when both ports enable the same lane of the same word.
  always_ff @(posedge i_clk) begin
    if (w_clearing) begin
      r_mem[r_clr_addr] <= CLEAR_VALUE;
    end else begin
      if (w_we_b) begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
          if (i_be_b[i]) begin
            r_mem[i_addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
      if (w_we_a) begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
          if (i_be_a[i]) begin
            r_mem[i_addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // First read stage; data holds when no read completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld_a <= 1'b0;
      r_rd_vld_b <= 1'b0;
      r_rd_dat_a <= '0;
      r_rd_dat_b <= '0;
    end else begin
      r_rd_vld_a <= w_rd_vld_a;
      r_rd_vld_b <= w_rd_vld_b;
      if (w_rd_vld_a) begin
        r_rd_dat_a <= w_rd_dat_a;
      end
      if (w_rd_vld_b) begin
        r_rd_dat_b <= w_rd_dat_b;
      end
    end
  end

  // Optional second read stage; not gated by clear so in-flight reads finish.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_rvalid_a <= 1'b0;
          o_rvalid_b <= 1'b0;
          o_rdata_a  <= '0;
          o_rdata_b  <= '0;
        end else begin
          o_rvalid_a <= r_rd_vld_a;
          o_rvalid_b <= r_rd_vld_b;
          if (r_rd_vld_a) begin
            o_rdata_a <= r_rd_dat_a;
          end
          if (r_rd_vld_b) begin
            o_rdata_b <= r_rd_dat_b;
          end
        end
      end
    end else begin : g_out_direct
      assign o_rvalid_a = r_rd_vld_a;
      assign o_rvalid_b = r_rd_vld_b;
      assign o_rdata_a  = r_rd_dat_a;
      assign o_rdata_b  = r_rd_dat_b;
    end
  endgenerate

  // Collision flag is always one cycle after the write, independent of OUT_REG.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_we_a & w_we_b & (i_addr_a == i_addr_b);
    end
  end

  assign o_collision = r_collision;

  // Clear sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_clr_addr <= '0;
      o_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      o_busy     <= w_busy_nxt;
    end
  end

  // Clear sequencer next state: one word per cycle, back to idle after DEPTH-1.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_busy_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clear) begin
          w_state_nxt    = S_CLEARING;
          w_clr_addr_nxt = '0;
          w_busy_nxt     = 1'b1;
        end
      end
      S_CLEARING: begin
        if (r_clr_addr == AW'(DEPTH - 1)) begin
          w_state_nxt    = S_IDLE;
          w_clr_addr_nxt = '0;
          w_busy_nxt     = 1'b0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + AW'(1);
          w_busy_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_clr_addr_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tdp_ram_param.sv
// ---------------------------------------------------------------------------
// tb_tdp_ram_param
//   Two instances driven by the same stimulus:
//     u_d0: DEPTH 32, A WRITE_FIRST, B READ_FIRST, latency 1, clear value 0
//     u_d1: DEPTH 24, A NO_CHANGE,  B WRITE_FIRST, latency 2, clear 18'h2A5A5
//   Reads and collisions are checked through a scoreboard of expected events
//   (channel, data, due cycle); every output pulse must match one entry.
// ---------------------------------------------------------------------------
module tb_tdp_ram_param;

  localparam logic [17:0] CV1 = 18'h2A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen_a, ren_a, wen_b, ren_b, clear;
  logic [1:0]  be_a, be_b;
  logic [4:0]  addr_a, addr_b;
  logic [17:0] wdata_a, wdata_b;

  logic [17:0] d0_rdata_a, d0_rdata_b, d1_rdata_a, d1_rdata_b;
  logic        d0_rvalid_a, d0_rvalid_b, d1_rvalid_a, d1_rvalid_b;
  logic        d0_busy, d1_busy, d0_col, d1_col;

  always #5 clk = ~clk;

  tdp_ram_param #(
    .DEPTH(32), .BYTE_WIDTH(9), .NUM_BYTES(2), .WRITE_MODE_A(0),
    .WRITE_MODE_B(1), .OUT_REG(0), .CLEAR_VALUE(18'h00000)
  ) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wen_a(wen_a), .i_ren_a(ren_a), .i_be_a(be_a), .i_addr_a(addr_a),
    .i_wdata_a(wdata_a), .o_rdata_a(d0_rdata_a), .o_rvalid_a(d0_rvalid_a),
    .i_wen_b(wen_b), .i_ren_b(ren_b), .i_be_b(be_b), .i_addr_b(addr_b),
    .i_wdata_b(wdata_b), .o_rdata_b(d0_rdata_b), .o_rvalid_b(d0_rvalid_b),
    .i_clear(clear), .o_busy(d0_busy), .o_collision(d0_col)
  );

  tdp_ram_param #(
    .DEPTH(24), .BYTE_WIDTH(9), .NUM_BYTES(2), .WRITE_MODE_A(2),
    .WRITE_MODE_B(0), .OUT_REG(1), .CLEAR_VALUE(CV1)
  ) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wen_a(wen_a), .i_ren_a(ren_a), .i_be_a(be_a), .i_addr_a(addr_a),
    .i_wdata_a(wdata_a), .o_rdata_a(d1_rdata_a), .o_rvalid_a(d1_rvalid_a),
    .i_wen_b(wen_b), .i_ren_b(ren_b), .i_be_b(be_b), .i_addr_b(addr_b),
    .i_wdata_b(wdata_b), .o_rdata_b(d1_rdata_b), .o_rvalid_b(d1_rvalid_b),
    .i_clear(clear), .o_busy(d1_busy), .o_collision(d1_col)
  );

  typedef struct {
    logic        wa, ra;
    logic [1:0]  bea;
    logic [4:0]  aa;
    logic [17:0] da;
    logic        wb, rb;
    logic [1:0]  beb;
    logic [4:0]  ab;
    logic [17:0] db;
    logic [17:0] xa0, xa1, xb0, xb1;
    logic        col;
  } vec_t;

  typedef struct {
    int          ch;
    logic [17:0] data;
    int unsigned due;
  } sb_t;

  sb_t         sb[$];
  vec_t        tbl[20];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cnt0, cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Match this cycle's output pulses against the scoreboard.
  task automatic monitor();
    logic        v;
    logic [17:0] d;
    int          idx;
    for (int ch = 0; ch < 6; ch++) begin
      case (ch)
        0:       begin v = d0_rvalid_a; d = d0_rdata_a; end
        1:       begin v = d0_rvalid_b; d = d0_rdata_b; end
        2:       begin v = d1_rvalid_a; d = d1_rdata_a; end
        3:       begin v = d1_rvalid_b; d = d1_rdata_b; end
        4:       begin v = d0_col;      d = 18'd1;      end
        default: begin v = d1_col;      d = 18'd1;      end
      endcase
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (idx < 0 && sb[i].ch == ch) idx = i;
      end
      if (v) begin
        if (idx < 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pulse ch%0d: got pulse data %h, want none (cycle %0d)", ch, d, cyc);
        end else begin
          chk($sformatf("ch%0d_data", ch), 32'(d), 32'(sb[idx].data));
          chk($sformatf("ch%0d_cycle", ch), cyc, sb[idx].due);
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].due <= cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_pulse ch%0d: got none, want data %h at cycle %0d", ch, sb[idx].data, sb[idx].due);
        sb.delete(idx);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic exp_rd(input bit port_b, input logic [17:0] d0, input logic [17:0] d1);
    sb.push_back('{ch: port_b ? 1 : 0, data: d0, due: cyc + 1});
    sb.push_back('{ch: port_b ? 3 : 2, data: d1, due: cyc + 2});
  endtask

  task automatic exp_col();
    sb.push_back('{ch: 4, data: 18'd1, due: cyc + 1});
    sb.push_back('{ch: 5, data: 18'd1, due: cyc + 1});
  endtask

  task automatic idle();
    wen_a = 0; ren_a = 0; be_a = 0; addr_a = 0; wdata_a = 0;
    wen_b = 0; ren_b = 0; be_b = 0; addr_b = 0; wdata_b = 0;
    clear = 0;
  endtask

  task automatic drive(input vec_t v);
    wen_a = v.wa; ren_a = v.ra; be_a = v.bea; addr_a = v.aa; wdata_a = v.da;
    wen_b = v.wb; ren_b = v.rb; be_b = v.beb; addr_b = v.ab; wdata_b = v.db;
    clear = 0;
    if (v.ra) exp_rd(1'b0, v.xa0, v.xa1);
    if (v.rb) exp_rd(1'b1, v.xb0, v.xb1);
    if (v.col) exp_col();
  endtask

  function automatic vec_t mk(
    input logic wa, input logic ra, input logic [1:0] bea, input logic [4:0] aa, input logic [17:0] da,
    input logic wb, input logic rb, input logic [1:0] beb, input logic [4:0] ab, input logic [17:0] db,
    input logic [17:0] xa0, input logic [17:0] xa1, input logic [17:0] xb0, input logic [17:0] xb1,
    input logic col);
    vec_t v;
    v.wa = wa; v.ra = ra; v.bea = bea; v.aa = aa; v.da = da;
    v.wb = wb; v.rb = rb; v.beb = beb; v.ab = ab; v.db = db;
    v.xa0 = xa0; v.xa1 = xa1; v.xb0 = xb0; v.xb1 = xb1; v.col = col;
    return v;
  endfunction

  function automatic logic [17:0] pat(input int i, input int s);
    return 18'(32'h155 + i * 32'h0A3 + s * 32'h1000);
  endfunction

  task automatic fill(input int s);
    for (int i = 0; i < 16; i++) begin
      idle();
      wen_a = 1; be_a = 2'b11; addr_a = 5'(2 * i);     wdata_a = pat(2 * i, s);
      wen_b = 1; be_b = 2'b11; addr_b = 5'(2 * i + 1); wdata_b = pat(2 * i + 1, s);
      tick();
    end
    idle();
  endtask

  initial begin
    // 9-bit lanes: lane1 = word[17:9], lane0 = word[8:0].
    tbl[0]  = mk(1,0,2'b11,5'd5,18'h3FFFF, 0,0,2'b00,5'd0,18'h0, 0,0,0,0, 0);
    tbl[1]  = mk(0,0,2'b00,5'd0,18'h0,     0,1,2'b00,5'd5,18'h0, 0,0,18'h3FFFF,18'h3FFFF, 0);
    tbl[2]  = mk(1,0,2'b11,5'd7,18'h0,     0,0,2'b00,5'd0,18'h0, 0,0,0,0, 0);
    tbl[3]  = mk(1,0,2'b01,5'd7,18'h1FF55, 0,0,2'b00,5'd0,18'h0, 0,0,0,0, 0);
    tbl[4]  = mk(0,0,2'b00,5'd0,18'h0,     0,1,2'b00,5'd7,18'h0, 0,0,18'h00155,18'h00155, 0);
    tbl[5]  = mk(1,0,2'b10,5'd7,18'h2AA00, 0,0,2'b00,5'd0,18'h0, 0,0,0,0, 0);
    tbl[6]  = mk(0,0,2'b00,5'd0,18'h0,     0,1,2'b00,5'd7,18'h0, 0,0,18'h2AB55,18'h2AB55, 0);
    tbl[7]  = mk(1,0,2'b01,5'd3,18'h0AAAA, 1,0,2'b11,5'd3,18'h25555, 0,0,0,0, 1);
    tbl[8]  = mk(0,1,2'b00,5'd3,18'h0,     0,0,2'b00,5'd0,18'h0, 18'h254AA,18'h254AA,0,0, 0);
    tbl[9]  = mk(0,1,2'b00,5'd5,18'h0,     1,0,2'b11,5'd5,18'h12345, 18'h3FFFF,18'h3FFFF,0,0, 0);
    tbl[10] = mk(1,0,2'b11,5'd9,18'h11111, 0,1,2'b00,5'd5,18'h0, 0,0,18'h12345,18'h12345, 0);
    tbl[11] = mk(1,0,2'b11,5'd25,18'h0F0F0, 0,0,2'b00,5'd0,18'h0, 0,0,0,0, 0);
    tbl[12] = mk(0,1,2'b00,5'd25,18'h0,    1,0,2'b11,5'd30,18'h3C3C3, 18'h0F0F0,18'h0,0,0, 0);
    tbl[13] = mk(0,0,2'b00,5'd0,18'h0,     0,1,2'b00,5'd30,18'h0, 0,0,18'h3C3C3,18'h0, 0);
    tbl[14] = mk(1,0,2'b11,5'd1,18'h00001, 1,0,2'b11,5'd2,18'h00002, 0,0,0,0, 0);
    tbl[15] = mk(0,1,2'b00,5'd2,18'h0,     0,1,2'b00,5'd1,18'h0, 18'h2,18'h2,18'h1,18'h1, 0);
    tbl[16] = mk(1,0,2'b11,5'd4,18'h0A0A0, 1,0,2'b11,5'd4,18'h15151, 0,0,0,0, 1);
    tbl[17] = mk(0,1,2'b00,5'd4,18'h0,     0,1,2'b00,5'd4,18'h0, 18'h0A0A0,18'h0A0A0,18'h0A0A0,18'h0A0A0, 0);
    tbl[18] = mk(1,0,2'b10,5'd6,18'h3FFFF, 1,0,2'b11,5'd6,18'h00000, 0,0,0,0, 1);
    tbl[19] = mk(0,0,2'b00,5'd0,18'h0,     0,1,2'b00,5'd6,18'h0, 0,0,18'h3FE00,18'h3FE00, 0);

    // Reset state.
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("d0_rdata_a_rst", 32'(d0_rdata_a), 0);
    chk("d0_rdata_b_rst", 32'(d0_rdata_b), 0);
    chk("d1_rdata_a_rst", 32'(d1_rdata_a), 0);
    chk("d1_rdata_b_rst", 32'(d1_rdata_b), 0);
    chk("d0_rvalid_rst", {30'd0, d0_rvalid_a, d0_rvalid_b}, 0);
    chk("d1_rvalid_rst", {30'd0, d1_rvalid_a, d1_rvalid_b}, 0);
    chk("d0_busy_rst", 32'(d0_busy), 0);
    chk("d1_busy_rst", 32'(d1_busy), 0);
    chk("d0_col_rst", 32'(d0_col), 0);
    chk("d1_col_rst", 32'(d1_col), 0);
    rst_n = 1'b1;
    tick();

    // Table: basic writes, lane merges, collisions, cross-port, out of range.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      tick();
    end
    idle();
    repeat (3) tick();

    // Same-port read-during-write on addr 9 (holds 0x11111).
    wen_a = 1; ren_a = 1; be_a = 2'b11; addr_a = 5'd9; wdata_a = 18'h22222;
    sb.push_back('{ch: 0, data: 18'h22222, due: cyc + 1});
    tick();
    idle();
    repeat (3) tick();
    chk("d1_nochange_hold", 32'(d1_rdata_a), 32'h0A0A0);
    wen_b = 1; ren_b = 1; be_b = 2'b11; addr_b = 5'd9; wdata_b = 18'h33333;
    exp_rd(1'b1, 18'h22222, 18'h33333);
    tick();
    wdata_b = 18'h00000; be_b = 2'b01;
    exp_rd(1'b1, 18'h33333, 18'h33200);
    tick();
    idle();
    ren_a = 1; addr_a = 5'd9;
    exp_rd(1'b0, 18'h33200, 18'h33200);
    tick();
    idle();
    repeat (3) tick();

    // Clear: in-flight read completes, ports ignored while busy.
    fill(0);
    clear = 1; ren_b = 1; addr_b = 5'd3;
    exp_rd(1'b1, pat(3, 0), pat(3, 0));
    tick();
    idle();
    cnt0 = 0;
    cnt1 = 0;
    for (int j = 0; j < 40; j++) begin
      if (d0_busy) cnt0++;
      if (d1_busy) cnt1++;
      idle();
      if (j >= 2 && j < 8) begin
        wen_a = 1; ren_a = 1; be_a = 2'b11; addr_a = 5'd0; wdata_a = 18'h3FFFF;
        wen_b = 1; ren_b = 1; be_b = 2'b11; addr_b = 5'd1; wdata_b = 18'h3FFFF;
        clear = (j == 4);
      end
      tick();
    end
    idle();
    chk("d0_busy_cycles", 32'(cnt0), 32);
    chk("d1_busy_cycles", 32'(cnt1), 24);
    for (int a = 0; a < 32; a++) begin
      ren_a = 1; addr_a = 5'(a);
      exp_rd(1'b0, 18'h0, (a < 24) ? CV1 : 18'h0);
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset while the clear counter sits at 12.
    fill(1);
    clear = 1;
    tick();
    idle();
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    chk("d0_busy_midreset", 32'(d0_busy), 0);
    chk("d1_busy_midreset", 32'(d1_busy), 0);
    chk("d0_rdata_b_midreset", 32'(d0_rdata_b), 0);
    chk("d1_rdata_b_midreset", 32'(d1_rdata_b), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      ren_b = 1; addr_b = 5'(a);
      exp_rd(1'b1, (a < 12) ? 18'h0 : pat(a, 1),
                   (a < 12) ? CV1 : ((a < 24) ? pat(a, 1) : 18'h0));
      tick();
    end
    idle();
    repeat (4) tick();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
